// File: rtl/usb_token_decoder.sv
// usb_token_decoder: decodes USB OUT/IN/SETUP/PING/SOF token packets with PID, CRC5 and length checks.
// Define USB_TOKEN_ADDR_FILTER_EN to drop non-SOF tokens whose address differs from dev_addr_i.
module usb_token_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        rx_last_i,
    input  logic        rx_abort_i,
    input  logic [6:0]  dev_addr_i,
    output logic        tok_valid_o,
    output logic [3:0]  tok_pid_o,
    output logic [6:0]  tok_addr_o,
    output logic [3:0]  tok_endp_o,
    output logic        sof_valid_o,
    output logic [10:0] sof_frame_o,
    output logic        err_pid_o,
    output logic        err_crc_o,
    output logic        err_len_o
);
    typedef enum logic [1:0] {IDLE, B1, B2, SKIP} state_t;

    state_t      state_q, state_d;
    logic [4:0]  crc_q, crc_d, crc_nx;
    logic [3:0]  pid_q, pid_d;
    logic [7:0]  b1_q, b1_d;
    logic        pid_ok, is_tok, crc_ok, addr_ok;
    logic        tok_d, sof_d, epid_d, ecrc_d, elen_d;
    logic        tok_q, sof_q, epid_q, ecrc_q, elen_q;
    logic [3:0]  tok_pid_q, tok_endp_q;
    logic [6:0]  tok_addr_q;
    logic [10:0] sof_frame_q;

    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] r;
        logic       m;
        r = c;
        for (int i = 0; i < 8; i++) begin
            m = r[4] ^ d[i];
            r = {r[3:0], 1'b0} ^ {2'b00, m, 1'b0, m};
        end
        return r;
    endfunction

    assign pid_ok = rx_data_i[7:4] == ~rx_data_i[3:0];
    assign is_tok = rx_data_i[3:0] inside {4'h1, 4'h9, 4'h5, 4'hD, 4'h4};
    assign crc_nx = crc5_byte(crc_q, rx_data_i);
    assign crc_ok = crc_nx == 5'h0C;

`ifdef USB_TOKEN_ADDR_FILTER_EN
    assign addr_ok = b1_q[6:0] == dev_addr_i;
`else
    logic unused_dev_addr;
    assign addr_ok = 1'b1;
    assign unused_dev_addr = ^dev_addr_i;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            crc_q       <= 5'h1F;
            pid_q       <= '0;
            b1_q        <= '0;
            tok_q       <= 1'b0;
            sof_q       <= 1'b0;
            epid_q      <= 1'b0;
            ecrc_q      <= 1'b0;
            elen_q      <= 1'b0;
            tok_pid_q   <= '0;
            tok_addr_q  <= '0;
            tok_endp_q  <= '0;
            sof_frame_q <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            pid_q   <= pid_d;
            b1_q    <= b1_d;
            tok_q   <= tok_d;
            sof_q   <= sof_d;
            epid_q  <= epid_d;
            ecrc_q  <= ecrc_d;
            elen_q  <= elen_d;
            if (tok_d) begin
                tok_pid_q  <= pid_q;
                tok_addr_q <= b1_q[6:0];
                tok_endp_q <= {rx_data_i[2:0], b1_q[7]};
            end
            if (sof_d) sof_frame_q <= {rx_data_i[2:0], b1_q};
        end
    end

    // CRC register sits at its init value in every state except B2.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        pid_d   = pid_q;
        b1_d    = b1_q;
        if (rx_abort_i) begin
            state_d = IDLE;
            crc_d   = 5'h1F;
        end else if (rx_valid_i) begin
            case (state_q)
                IDLE: begin
                    pid_d   = rx_data_i[3:0];
                    state_d = (pid_ok && is_tok && !rx_last_i) ? B1 : rx_last_i ? IDLE : SKIP;
                end
                B1: begin
                    b1_d    = rx_data_i;
                    crc_d   = rx_last_i ? 5'h1F : crc_nx;
                    state_d = rx_last_i ? IDLE : B2;
                end
                B2: begin
                    crc_d   = 5'h1F;
                    state_d = rx_last_i ? IDLE : SKIP;
                end
                default: state_d = rx_last_i ? IDLE : SKIP;
            endcase
        end
    end

    always_comb begin
        tok_d  = 1'b0;
        sof_d  = 1'b0;
        epid_d = 1'b0;
        ecrc_d = 1'b0;
        elen_d = 1'b0;
        if (!rx_abort_i && rx_valid_i) begin
            case (state_q)
                IDLE: begin
                    epid_d = !pid_ok;
                    elen_d = pid_ok && is_tok && rx_last_i;
                end
                B1: elen_d = rx_last_i;
                B2: begin
                    elen_d = !rx_last_i;
                    ecrc_d = rx_last_i && !crc_ok;
                    sof_d  = rx_last_i && crc_ok && pid_q == 4'h5;
                    tok_d  = rx_last_i && crc_ok && pid_q != 4'h5 && addr_ok;
                end
                default: ;
            endcase
        end
    end

    assign tok_valid_o = tok_q;
    assign sof_valid_o = sof_q;
    assign err_pid_o   = epid_q;
    assign err_crc_o   = ecrc_q;
    assign err_len_o   = elen_q;
    assign tok_pid_o   = tok_pid_q;
    assign tok_addr_o  = tok_addr_q;
    assign tok_endp_o  = tok_endp_q;
    assign sof_frame_o = sof_frame_q;
endmodule

// File: tb/tb_usb_token_decoder.sv
// tb_usb_token_decoder: directed self-checking bench for usb_token_decoder.
// Pulses are checked as {tok, sof, err_pid, err_crc, err_len} one cycle after each byte.
module tb_usb_token_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_last = 1'b0;
    logic        rx_abort = 1'b0;
    logic [6:0]  dev_addr = '0;
    logic        tok_valid, sof_valid, err_pid, err_crc, err_len;
    logic [3:0]  tok_pid, tok_endp;
    logic [6:0]  tok_addr;
    logic [10:0] sof_frame;
    logic [4:0]  pulses;
    int          total = 0;
    int          passed = 0;

    localparam logic [4:0] NONE = 5'b00000, TOK = 5'b10000, SOF = 5'b01000,
                           EP = 5'b00100, EC = 5'b00010, EL = 5'b00001;

    usb_token_decoder dut (
        .clk(clk), .rst(rst),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_last_i(rx_last),
        .rx_abort_i(rx_abort), .dev_addr_i(dev_addr),
        .tok_valid_o(tok_valid), .tok_pid_o(tok_pid), .tok_addr_o(tok_addr), .tok_endp_o(tok_endp),
        .sof_valid_o(sof_valid), .sof_frame_o(sof_frame),
        .err_pid_o(err_pid), .err_crc_o(err_crc), .err_len_o(err_len)
    );

    always #5 clk = ~clk;
    assign pulses = {tok_valid, sof_valid, err_pid, err_crc, err_len};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic b(input logic [7:0] d, input logic l, input logic [4:0] e, input string tag);
        rx_data = d; rx_valid = 1'b1; rx_last = l;
        @(negedge clk);
        rx_valid = 1'b0; rx_last = 1'b0;
        chk(tag, {11'd0, pulses}, {11'd0, e});
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        chk(tag, {11'd0, pulses}, 16'd0);
    endtask

    task automatic fields(input string tag, input logic [3:0] p, input logic [6:0] a, input logic [3:0] e);
        chk({tag, "_pid"}, {12'd0, tok_pid}, {12'd0, p});
        chk({tag, "_addr"}, {9'd0, tok_addr}, {9'd0, a});
        chk({tag, "_endp"}, {12'd0, tok_endp}, {12'd0, e});
    endtask

    initial begin
        @(negedge clk); @(negedge clk);
        chk("rst_pulses", {11'd0, pulses}, 16'd0);
        fields("rst", 4'h0, 7'h00, 4'h0);
        chk("rst_frame", {5'd0, sof_frame}, 16'd0);
        rst = 1'b0;
        @(negedge clk);
        // SETUP addr 0 endp 0
        b(8'h2D, 0, NONE, "setup_b0"); b(8'h00, 0, NONE, "setup_b1"); b(8'h10, 1, TOK, "setup_b2");
        fields("setup", 4'hD, 7'h00, 4'h0);
        idle("setup_one_cycle");
        b(8'hA5, 0, NONE, "sof_b0"); b(8'h00, 0, NONE, "sof_b1"); b(8'h10, 1, SOF, "sof_b2");
        chk("sof_frame0", {5'd0, sof_frame}, 16'h000);
        fields("sof_hold", 4'hD, 7'h00, 4'h0);
        b(8'h2D, 0, NONE, "bad_b0"); b(8'h00, 0, NONE, "bad_b1"); b(8'h11, 1, EC, "bad_crc");
        fields("crc_hold", 4'hD, 7'h00, 4'h0);
        // OUT addr 1 endp 0, IN addr 0 endp 1
        dev_addr = 7'd1;
        b(8'hE1, 0, NONE, "out_b0"); b(8'h01, 0, NONE, "out_b1"); b(8'hE8, 1, TOK, "out_b2");
        fields("out", 4'h1, 7'h01, 4'h0);
        dev_addr = 7'd0;
        b(8'h69, 0, NONE, "in_b0"); b(8'h80, 0, NONE, "in_b1"); b(8'hA0, 1, TOK, "in_b2");
        fields("in_ep1", 4'h9, 7'h00, 4'h1);
        b(8'hA5, 0, NONE, "sof1_b0"); b(8'h01, 0, NONE, "sof1_b1"); b(8'hE8, 1, SOF, "sof1_b2");
        chk("sof_frame1", {5'd0, sof_frame}, 16'h001);
        // bad PID, then the remainder of that packet is skipped
        b(8'h2C, 0, EP, "pid_err"); b(8'h11, 0, NONE, "skip_b1"); b(8'h22, 1, NONE, "skip_b2");
        b(8'h2D, 0, NONE, "short_b0"); b(8'h00, 1, EL, "short_len");
        b(8'h2D, 1, EL, "pid_only_len");
        b(8'h2D, 0, NONE, "long_b0"); b(8'h00, 0, NONE, "long_b1"); b(8'h10, 0, EL, "long_len");
        b(8'h55, 1, NONE, "long_tail");
        b(8'hA5, 0, NONE, "rec_b0"); b(8'h00, 0, NONE, "rec_b1"); b(8'h10, 1, SOF, "rec_sof");
        b(8'hC3, 0, NONE, "data_b0"); b(8'h11, 0, NONE, "data_b1"); b(8'h22, 1, NONE, "data_ignored");
        // abort in place of byte2
        b(8'h2D, 0, NONE, "ab_b0"); b(8'h00, 0, NONE, "ab_b1");
        rx_abort = 1'b1;
        b(8'h10, 1, NONE, "abort_suppress");
        rx_abort = 1'b0;
        b(8'h69, 0, NONE, "post_ab_b0"); b(8'h00, 0, NONE, "post_ab_b1"); b(8'h10, 1, TOK, "post_ab_tok");
        fields("post_ab", 4'h9, 7'h00, 4'h0);
        // stalls between bytes
        b(8'h2D, 0, NONE, "st_b0"); idle("stall0");
        b(8'h00, 0, NONE, "st_b1"); idle("stall1"); idle("stall2");
        b(8'h10, 1, TOK, "stall_tok");
        fields("stall", 4'hD, 7'h00, 4'h0);
        // reset mid-packet; next byte must be a PID again
        b(8'hE1, 0, NONE, "mr_b0"); b(8'h01, 0, NONE, "mr_b1");
        rst = 1'b1;
        @(negedge clk);
        fields("midrst", 4'h0, 7'h00, 4'h0);
        rst = 1'b0;
        b(8'hA5, 0, NONE, "mr_sof_b0"); b(8'h80, 0, NONE, "mr_sof_b1"); b(8'hA0, 1, SOF, "mr_sof");
        chk("sof_frame80", {5'd0, sof_frame}, 16'h080);
        // address filter
        dev_addr = 7'd5;
`ifdef USB_TOKEN_ADDR_FILTER_EN
        b(8'h2D, 0, NONE, "f_b0"); b(8'h00, 0, NONE, "f_b1"); b(8'h10, 1, NONE, "filt_drop");
        fields("filt", 4'h0, 7'h00, 4'h0);
`else
        b(8'h2D, 0, NONE, "f_b0"); b(8'h00, 0, NONE, "f_b1"); b(8'h10, 1, TOK, "filt_pass");
        fields("filt", 4'hD, 7'h00, 4'h0);
`endif
        b(8'hA5, 0, NONE, "fs_b0"); b(8'h00, 0, NONE, "fs_b1"); b(8'h10, 1, SOF, "filt_sof");
        chk("filt_frame", {5'd0, sof_frame}, 16'h000);
        idle("final_idle");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
